// File: rtl/foreground_object_scheduler.sv
// Per-scanline foreground sprite evaluator: scans Object Memory in index order and
// emits up to MAX_SLOTS slot records (X, pattern row, color, hflip) for target_y.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for line_start
// RD_Y  | issue OBM read of object Y (byte 1)
// CHK_Y | hit test on Y; pick next object, overflow exit or fetch
// RD_X  | issue OBM read of X (byte 0)
// RD_A  | capture X; issue read of attr (byte 2)
// RD_C  | capture attr; issue read of color (byte 3)
// RD_P0 | capture color; issue PMF read of pattern high byte
// RD_P1 | capture high byte; issue PMF read of pattern low byte
// WRITE | slot_we with low byte forwarded straight from pmf_data
// DONE  | one-cycle done pulse
module foreground_object_scheduler #(
  parameter int NUM_OBJECTS = 64,
  parameter int MAX_SLOTS   = 8,
  localparam int IDX_W = (MAX_SLOTS > 1) ? $clog2(MAX_SLOTS) : 1,
  localparam int CNT_W = $clog2(MAX_SLOTS + 1)
) (
  input  logic             clk_12_5875,
  input  logic             rst,
  input  logic             line_start,
  input  logic [7:0]       target_y,
  output logic [7:0]       obm_addr,
  input  logic [7:0]       obm_data,
  output logic [8:0]       pmf_addr,
  input  logic [7:0]       pmf_data,
  output logic             slot_we,
  output logic [IDX_W-1:0] slot_idx,
  output logic [7:0]       slot_x,
  output logic [15:0]      slot_line,
  output logic [2:0]       slot_color,
  output logic             slot_hflip,
  output logic [CNT_W-1:0] slot_count,
  output logic             busy,
  output logic             done,
  output logic             overflow
);

  typedef enum logic [3:0] {
    IDLE, RD_Y, CHK_Y, RD_X, RD_A, RD_C, RD_P0, RD_P1, WRITE, DONE
  } state_t;

  localparam logic [5:0]       LAST_IDX  = 6'(NUM_OBJECTS - 1);
  localparam logic [CNT_W-1:0] SLOT_FULL = CNT_W'(MAX_SLOTS);

  state_t state, state_n;

  logic [7:0]  ty_q;
  logic [5:0]  obma;
  logic [2:0]  row_q;
  logic [7:0]  x_q;
  logic [4:0]  pmfa_q;
  logic        vflip_q;
  logic        hflip_q;
  logic [2:0]  color_q;
  logic [7:0]  hi_q;

  logic [IDX_W-1:0] held_idx;
  logic [7:0]       held_x;
  logic [15:0]      held_line;
  logic [2:0]       held_color;
  logic             held_hflip;

  logic       y_hit;
  logic       obma_last;
  logic       slots_full;
  logic [2:0] pat_row;

  // No wrap at the bottom of the frame: the 9-bit add keeps Y=0xFC from reaching line 0.
  assign y_hit      = (obm_data <= ty_q) && ({1'b0, ty_q} < ({1'b0, obm_data} + 9'd8));
  assign obma_last  = (obma == LAST_IDX);
  assign slots_full = (slot_count == SLOT_FULL);
  assign pat_row    = vflip_q ? (3'd7 - row_q) : row_q;

  always_ff @(posedge clk_12_5875 or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n    = state;
    obm_addr   = 8'd0;
    pmf_addr   = 9'd0;
    slot_we    = 1'b0;
    slot_idx   = held_idx;
    slot_x     = held_x;
    slot_line  = held_line;
    slot_color = held_color;
    slot_hflip = held_hflip;
    busy       = (state != IDLE);
    done       = 1'b0;

    case (state)
      IDLE:  state_n = IDLE;
      RD_Y: begin
        obm_addr = {obma, 2'd1};
        state_n  = CHK_Y;
      end
      CHK_Y: begin
        if (!y_hit)          state_n = obma_last ? DONE : RD_Y;
        else if (slots_full) state_n = DONE;
        else                 state_n = RD_X;
      end
      RD_X: begin
        obm_addr = {obma, 2'd0};
        state_n  = RD_A;
      end
      RD_A: begin
        obm_addr = {obma, 2'd2};
        state_n  = RD_C;
      end
      RD_C: begin
        obm_addr = {obma, 2'd3};
        state_n  = RD_P0;
      end
      RD_P0: begin
        pmf_addr = {pmfa_q, pat_row, 1'b0};
        state_n  = RD_P1;
      end
      RD_P1: begin
        pmf_addr = {pmfa_q, pat_row, 1'b1};
        state_n  = WRITE;
      end
      WRITE: begin
        slot_we    = 1'b1;
        slot_idx   = slot_count[IDX_W-1:0];
        slot_x     = x_q;
        slot_line  = {hi_q, pmf_data};
        slot_color = color_q;
        slot_hflip = hflip_q;
        state_n    = obma_last ? DONE : RD_Y;
      end
      DONE: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    // A new line_start always wins, including mid-scan aborts.
    if (line_start) state_n = RD_Y;
  end

  always_ff @(posedge clk_12_5875 or negedge rst) begin
    if (!rst) begin
      ty_q       <= 8'd0;
      obma       <= 6'd0;
      row_q      <= 3'd0;
      x_q        <= 8'd0;
      pmfa_q     <= 5'd0;
      vflip_q    <= 1'b0;
      hflip_q    <= 1'b0;
      color_q    <= 3'd0;
      hi_q       <= 8'd0;
      slot_count <= '0;
      overflow   <= 1'b0;
      held_idx   <= '0;
      held_x     <= 8'd0;
      held_line  <= 16'd0;
      held_color <= 3'd0;
      held_hflip <= 1'b0;
    end else if (line_start) begin
      ty_q       <= target_y;
      obma       <= 6'd0;
      slot_count <= '0;
      overflow   <= 1'b0;
    end else begin
      case (state)
        CHK_Y: begin
          if (!y_hit) begin
            if (!obma_last) obma <= obma + 6'd1;
          end else if (slots_full) begin
            overflow <= 1'b1;
          end else begin
            row_q <= ty_q[2:0] - obm_data[2:0];
          end
        end
        RD_A:  x_q <= obm_data;
        RD_C: begin
          pmfa_q  <= obm_data[4:0];
          vflip_q <= obm_data[5];
          hflip_q <= obm_data[6];
        end
        RD_P0: color_q <= obm_data[2:0];
        RD_P1: hi_q    <= pmf_data;
        WRITE: begin
          held_idx   <= slot_count[IDX_W-1:0];
          held_x     <= x_q;
          held_line  <= {hi_q, pmf_data};
          held_color <= color_q;
          held_hflip <= hflip_q;
          slot_count <= slot_count + CNT_W'(1);
          if (!obma_last) obma <= obma + 6'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_foreground_object_scheduler.sv
// Bench for foreground_object_scheduler: OBM/PMF modelled as 1-cycle-latency arrays,
// single-object vectors from a table plus overflow, reset and abort sequences.
module tb_foreground_object_scheduler;

  logic        clk_12_5875 = 1'b0;
  logic        rst = 1'b0;
  logic        line_start = 1'b0;
  logic [7:0]  target_y = 8'd0;
  logic [7:0]  obm_addr;
  logic [7:0]  obm_data = 8'd0;
  logic [8:0]  pmf_addr;
  logic [7:0]  pmf_data = 8'd0;
  logic        slot_we;
  logic [2:0]  slot_idx;
  logic [7:0]  slot_x;
  logic [15:0] slot_line;
  logic [2:0]  slot_color;
  logic        slot_hflip;
  logic [3:0]  slot_count;
  logic        busy;
  logic        done;
  logic        overflow;

  foreground_object_scheduler dut (
    .clk_12_5875(clk_12_5875), .rst(rst), .line_start(line_start), .target_y(target_y),
    .obm_addr(obm_addr), .obm_data(obm_data), .pmf_addr(pmf_addr), .pmf_data(pmf_data),
    .slot_we(slot_we), .slot_idx(slot_idx), .slot_x(slot_x), .slot_line(slot_line),
    .slot_color(slot_color), .slot_hflip(slot_hflip), .slot_count(slot_count),
    .busy(busy), .done(done), .overflow(overflow)
  );

  always #5 clk_12_5875 = ~clk_12_5875;

  logic [7:0] obm [256];
  logic [7:0] pmf [512];

  always @(posedge clk_12_5875) begin
    obm_data <= obm[obm_addr];
    pmf_data <= pmf[pmf_addr];
  end

  typedef struct {
    int          idx;
    logic [7:0]  x;
    logic [15:0] line;
    logic [2:0]  color;
    logic        hflip;
  } slot_ev_t;

  slot_ev_t   ev_q[$];
  logic [8:0] pa_q[$];
  int         rdy_q[$];
  int         done_cnt = 0;

  always @(negedge clk_12_5875) begin
    slot_ev_t e;
    if (slot_we) begin
      e.idx = int'(slot_idx); e.x = slot_x; e.line = slot_line;
      e.color = slot_color; e.hflip = slot_hflip;
      ev_q.push_back(e);
    end
    if (done) done_cnt++;
    if (pmf_addr != 9'd0) pa_q.push_back(pmf_addr);
    if (busy && obm_addr[1:0] == 2'd1) rdy_q.push_back(int'(obm_addr[7:2]));
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return {8'd0, obm_addr, pmf_addr, slot_we, slot_idx, slot_x, slot_line, slot_color,
            slot_hflip, slot_count, busy, done, overflow};
  endfunction

  task automatic set_obj(input int idx, input logic [7:0] y, input logic [7:0] x,
                         input logic [7:0] attr, input logic [7:0] color);
    obm[idx*4 + 0] = x;
    obm[idx*4 + 1] = y;
    obm[idx*4 + 2] = attr;
    obm[idx*4 + 3] = color;
  endtask

  task automatic fill_bg(input logic [7:0] y);
    for (int i = 0; i < 64; i++) set_obj(i, y, 8'h00, 8'h00, 8'h00);
  endtask

  task automatic start_line(input logic [7:0] ty);
    @(posedge clk_12_5875); #1;
    target_y = ty;
    line_start = 1'b1;
    @(posedge clk_12_5875); #1;
    line_start = 1'b0;
  endtask

  // Returns the cycle offset of done relative to the line_start cycle, -1 on timeout.
  task automatic wait_done(output int cyc);
    cyc = 1;
    while (!done && cyc < 400) begin
      @(posedge clk_12_5875); #1;
      cyc++;
    end
    if (!done) cyc = -1;
  endtask

  typedef struct {
    int         idx;
    logic [7:0] bg_y, y, x, attr;
    logic [2:0] color;
    logic [7:0] ty;
    logic       hit;
    logic [8:0] pa;
    logic       hflip;
    int         cycles;
  } vec_t;

  function automatic vec_t mk(int idx, logic [7:0] bg_y, logic [7:0] y, logic [7:0] x,
                              logic [7:0] attr, logic [2:0] color, logic [7:0] ty,
                              logic hit, logic [8:0] pa, logic hflip, int cycles);
    vec_t v;
    v.idx = idx; v.bg_y = bg_y; v.y = y; v.x = x; v.attr = attr; v.color = color;
    v.ty = ty; v.hit = hit; v.pa = pa; v.hflip = hflip; v.cycles = cycles;
    return v;
  endfunction

  vec_t vecs[10];

  initial begin
    int cyc, ev_base, pa_base, rd_base, done_base, max_rd, n;
    logic [15:0] exp_line;

    // idx, bg_y, y, x, attr, color, ty, hit, pmf_addr, hflip, done offset
    vecs[0] = mk(5,  8'hFF, 8'h0E, 8'h20, 8'h03, 3'd5, 8'h10, 1'b1, 9'h034, 1'b0, 135);
    vecs[1] = mk(5,  8'hFF, 8'h0E, 8'h20, 8'h23, 3'd5, 8'h10, 1'b1, 9'h03A, 1'b0, 135);
    vecs[2] = mk(5,  8'hFF, 8'h0E, 8'h20, 8'h43, 3'd5, 8'h10, 1'b1, 9'h034, 1'b1, 135);
    vecs[3] = mk(0,  8'hFF, 8'hFC, 8'h11, 8'h04, 3'd1, 8'h02, 1'b0, 9'h000, 1'b0, 129);
    vecs[4] = mk(0,  8'h00, 8'hFC, 8'h7F, 8'h1F, 3'd7, 8'hFF, 1'b1, 9'h1F6, 1'b0, 135);
    vecs[5] = mk(63, 8'hFF, 8'h10, 8'h3C, 8'h01, 3'd2, 8'h17, 1'b1, 9'h01E, 1'b0, 135);
    vecs[6] = mk(10, 8'hFF, 8'h10, 8'h00, 8'h01, 3'd0, 8'h18, 1'b0, 9'h000, 1'b0, 129);
    vecs[7] = mk(1,  8'hFF, 8'h11, 8'h00, 8'h01, 3'd0, 8'h10, 1'b0, 9'h000, 1'b0, 129);
    vecs[8] = mk(2,  8'hFF, 8'h10, 8'h55, 8'h22, 3'd3, 8'h17, 1'b1, 9'h020, 1'b0, 135);
    vecs[9] = mk(0,  8'hFF, 8'hFF, 8'h00, 8'h00, 3'd0, 8'h10, 1'b0, 9'h000, 1'b0, 129);

    for (int i = 0; i < 512; i++) pmf[i] = 8'((i * 37 + 11) ^ (i >> 3));
    fill_bg(8'hFF);

    repeat (3) @(posedge clk_12_5875);
    #1;
    check("reset_outputs", all_outs(), 64'd0);
    rst = 1'b1;
    repeat (2) @(posedge clk_12_5875);
    #1;
    check("idle_outputs", all_outs(), 64'd0);

    for (int v = 0; v < 10; v++) begin
      fill_bg(vecs[v].bg_y);
      set_obj(vecs[v].idx, vecs[v].y, vecs[v].x, vecs[v].attr, {5'b10101, vecs[v].color});
      ev_base = ev_q.size();
      pa_base = pa_q.size();
      start_line(vecs[v].ty);
      wait_done(cyc);
      check($sformatf("v%0d_done_cycles", v), 64'(cyc), 64'(vecs[v].cycles));
      check($sformatf("v%0d_slot_count", v), 64'(slot_count), 64'(vecs[v].hit));
      check($sformatf("v%0d_overflow", v), 64'(overflow), 64'd0);
      repeat (2) @(posedge clk_12_5875);
      #1;
      check($sformatf("v%0d_we_count", v), 64'(ev_q.size() - ev_base), 64'(vecs[v].hit));
      if (vecs[v].hit && ev_q.size() > ev_base && pa_q.size() > pa_base + 1) begin
        exp_line = {pmf[vecs[v].pa], pmf[vecs[v].pa + 9'd1]};
        check($sformatf("v%0d_pmf_addr_hi", v), 64'(pa_q[pa_base]), 64'(vecs[v].pa));
        check($sformatf("v%0d_pmf_addr_lo", v), 64'(pa_q[pa_base + 1]), 64'(vecs[v].pa + 9'd1));
        check($sformatf("v%0d_slot_idx", v), 64'(ev_q[ev_base].idx), 64'd0);
        check($sformatf("v%0d_slot_x", v), 64'(ev_q[ev_base].x), 64'(vecs[v].x));
        check($sformatf("v%0d_slot_line", v), 64'(ev_q[ev_base].line), 64'(exp_line));
        check($sformatf("v%0d_slot_color", v), 64'(ev_q[ev_base].color), 64'(vecs[v].color));
        check($sformatf("v%0d_slot_hflip", v), 64'(ev_q[ev_base].hflip), 64'(vecs[v].hflip));
      end else if (vecs[v].hit) begin
        check($sformatf("v%0d_missing_records", v), 64'd0, 64'd1);
      end
    end

    // Overflow: objects 0..9 all hit, only 0..7 get slots.
    fill_bg(8'hFF);
    for (int i = 0; i < 10; i++) set_obj(i, 8'h10, 8'(8'h10 + i), 8'(1 + i), 8'(i));
    ev_base = ev_q.size();
    rd_base = rdy_q.size();
    start_line(8'h10);
    wait_done(cyc);
    check("ovf_done_cycles", 64'(cyc), 64'd67);
    check("ovf_slot_count", 64'(slot_count), 64'd8);
    check("ovf_overflow", 64'(overflow), 64'd1);
    repeat (5) @(posedge clk_12_5875);
    #1;
    check("ovf_overflow_held", 64'(overflow), 64'd1);
    check("ovf_we_count", 64'(ev_q.size() - ev_base), 64'd8);
    for (int k = 0; k < 8; k++) begin
      if (ev_q.size() > ev_base + k) begin
        exp_line = {pmf[9'((1 + k) << 4)], pmf[9'(((1 + k) << 4) + 1)]};
        check($sformatf("ovf_slot%0d_idx", k), 64'(ev_q[ev_base + k].idx), 64'(k));
        check($sformatf("ovf_slot%0d_x", k), 64'(ev_q[ev_base + k].x), 64'(8'h10 + k));
        check($sformatf("ovf_slot%0d_line", k), 64'(ev_q[ev_base + k].line), 64'(exp_line));
        check($sformatf("ovf_slot%0d_color", k), 64'(ev_q[ev_base + k].color), 64'(k));
      end
    end
    max_rd = -1;
    for (int i = rd_base; i < rdy_q.size(); i++) if (rdy_q[i] > max_rd) max_rd = rdy_q[i];
    check("ovf_last_obj_read", 64'(max_rd), 64'd8);
    check("hold_slot_x", 64'(slot_x), 64'h17);

    // New line clears overflow; reset it asynchronously mid-scan.
    start_line(8'h00);
    check("ovf_cleared", 64'(overflow), 64'd0);
    repeat (20) @(posedge clk_12_5875);
    #2;
    rst = 1'b0;
    #1;
    check("async_reset_outputs", all_outs(), 64'd0);
    @(posedge clk_12_5875); #1;
    rst = 1'b1;
    repeat (3) @(posedge clk_12_5875);
    #1;
    check("post_reset_idle", {63'd0, busy}, 64'd0);

    // Abort in RD_C of object 5, restart the same line.
    fill_bg(8'hFF);
    set_obj(5, 8'h0E, 8'h20, 8'h03, 8'h05);
    ev_base = ev_q.size();
    done_base = done_cnt;
    start_line(8'h10);
    n = 0;
    while (obm_addr != 8'h17 && n < 100) begin
      @(posedge clk_12_5875); #1;
      n++;
    end
    check("abort_reach_rd_c", 64'(obm_addr), 64'h17);
    target_y = 8'h10;
    line_start = 1'b1;
    @(posedge clk_12_5875); #1;
    line_start = 1'b0;
    wait_done(cyc);
    check("abort_done_cycles", 64'(cyc), 64'd135);
    repeat (10) @(posedge clk_12_5875);
    #1;
    check("abort_done_pulses", 64'(done_cnt - done_base), 64'd1);
    check("abort_we_count", 64'(ev_q.size() - ev_base), 64'd1);
    check("abort_slot_count", 64'(slot_count), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/foreground_object_scheduler.md
# foreground_object_scheduler

Per-scanline sprite evaluator for the foreground path. On each `line_start` pulse it scans Object Memory in ascending index order and selects up to `MAX_SLOTS` objects that intersect `target_y`. For each selected object it fetches the 16-bit pattern row from Pattern Memory Foreground and writes one slot record to the downstream line-slot buffer. The flat 64-way per-pixel compare is thereby replaced with a small per-line slot table. Lower object index has higher priority, matching the foreground first-set rule.

## Interface
- `NUM_OBJECTS`, 64, objects scanned (1..64; OBM index width 6).
- `MAX_SLOTS`, 8, max objects per line (1..16).
- `clk_12_5875`  in  1  pixel clock; all logic on posedge.
- `rst`  in  1  asynchronous, active-low reset.
- `line_start`  in  1  one-cycle pulse: begin evaluation for `target_y`.
- `target_y`  in  8  line being prepared; sampled on `line_start`.
- `obm_addr`  out  8  OBM byte address ({obma[5:0], byte[1:0]}).
- `obm_data`  in  8  OBM read data, valid the cycle after `obm_addr`.
- `pmf_addr`  out  9  PMF byte address ({pmfa[4:0], row[2:0], hi_lo}).
- `pmf_data`  in  8  PMF read data, valid the cycle after `pmf_addr`.
- `slot_we`  out  1  one-cycle slot write strobe.
- `slot_idx`  out  $clog2(MAX_SLOTS)  slot being written.
- `slot_x`  out  8  object X.
- `slot_line`  out  16  pattern row, {PMF[..0], PMF[..1]}, 2 bpp, MSB pair = leftmost pixel.
- `slot_color`  out  3  object color (attr byte 3, bits [2:0]).
- `slot_hflip`  out  1  attr byte 2, bit 6.
- `slot_count`  out  $clog2(MAX_SLOTS+1)  slots written this line.
- `busy`  out  1  evaluation in progress.
- `done`  out  1  one-cycle pulse when evaluation ends.
- `overflow`  out  1  more than `MAX_SLOTS` objects hit this line; held until next `line_start`.

## Operation
- States: IDLE, RD_Y, CHK_Y, RD_X, RD_A, RD_C, RD_P0, RD_P1, WRITE, DONE.
- IDLE: on `line_start`, latch `target_y`, clear obma, `slot_count` and `overflow`, then go to RD_Y.
- RD_Y: `obm_addr={obma,2'd1}`.
- CHK_Y: evaluate Y = `obm_data`.
  - Hit test: `Y <= target_y && {1'b0,target_y} < {1'b0,Y}+9'd8`. No wrap, so Y=0xFC covers lines 0xFC..0xFF only.
  - Miss: if obma==NUM_OBJECTS-1, go to DONE; otherwise obma+1 and go to RD_Y.
  - Hit with `slot_count==MAX_SLOTS`: set `overflow` and go to DONE.
  - Hit otherwise: latch row=`target_y[2:0]-Y[2:0]` (3-bit modular) and go to RD_X.
- RD_X: `obm_addr={obma,2'd0}`.
- RD_A: capture X; `obm_addr={obma,2'd2}`.
- RD_C: capture attr (pmfa=[4:0], vflip=[5], hflip=[6]); `obm_addr={obma,2'd3}`.
- RD_P0: capture color; `pmf_addr={pmfa, vflip?3'd7-row:row, 1'b0}`.
- RD_P1: capture high byte; `pmf_addr` LSB=1.
- WRITE: capture low byte and assert `slot_we` with `slot_idx=slot_count`. Then increment `slot_count`. If obma==NUM_OBJECTS-1, go to DONE; otherwise obma+1 and go to RD_Y.
- DONE: pulse `done` and go to IDLE.
- `busy` is 1 in every state except IDLE.
- `line_start` in any non-IDLE state aborts the current scan. The FSM restarts from IDLE-entry behaviour with the new `target_y`; no `done` pulse is issued for the aborted line. Slots already written remain stale downstream; the consumer uses `slot_count`.
- Slot outputs hold their last values when `slot_we`=0.

## Timing
- Read ports have a fixed 1-cycle latency. The controller never issues back-to-back dependent reads without a capture state.
- Miss costs 2 cycles (RD_Y, CHK_Y). Hit costs 8 cycles (RD_Y..WRITE).
- From `line_start` to `done`: 1 + 2·N_miss + 8·N_hit + 1 cycles. Worst case at defaults is 1+112+64+1 = 178 cycles, which is less than one line period.
- Overflow exit: the cycle after CHK_Y enters DONE, and `done` pulses the following cycle.
- Reset (async assert): state=IDLE, all outputs 0 (`obm_addr`, `pmf_addr`, `slot_*`, `slot_count`, `busy`, `done`, `overflow`). Reset mid-scan discards all progress.

## Test plan
- All Y=0xFF, `target_y`=0x10 → no `slot_we`; `done` 129 cycles after `line_start`; `slot_count`=0, `overflow`=0.
- Object 5: X=0x20, Y=0x0E, attr=0x03, color=0x5; `target_y`=0x10 → row 2, `pmf_addr` 0x034 then 0x035. One `slot_we` with slot_idx 0, slot_x 0x20, slot_color 5, `slot_line`={PMF[0x34],PMF[0x35]}.
- Same object with vflip=1 → row 5, `pmf_addr` 0x03A/0x03B. With hflip=1 → `slot_hflip`=1.
- Objects 0..9 all hit → slots 0..7 hold objects 0..7 in order; `overflow`=1 on object 8; object 9 is never read; `slot_count`=8.
- Y=0xFC, `target_y`=0x02 → miss (no wrap). `target_y`=0xFF → hit, row 3.
- `line_start` asserted mid-hit (in RD_C) → scan restarts, only one `done` pulse. Async `rst` low mid-scan → all outputs 0 immediately, FSM in IDLE.
